// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and sizing helpers for the clock-gate controller.
// The state encoding and the shared counter width live here so that any block can reuse them.
package clk_gate_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    IDLE_WAIT = 3'd1,
    QUIESCE   = 3'd2,
    OFF       = 3'd3,
    WAKE      = 3'd4
  } state_e;

  localparam int DEFAULT_IDLE_CYCLES = 16;
  localparam int DEFAULT_WAKE_CYCLES = 2;
  localparam int DEFAULT_CNT_W       = 16;

  // The counter only ever needs to reach max(idle, wake) - 1.
  function automatic int cnt_width(input int idle_cycles, input int wake_cycles);
    int m;
    m = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int DEFAULT_TIMER_W = cnt_width(DEFAULT_IDLE_CYCLES, DEFAULT_WAKE_CYCLES);

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Handshake bundle between the gating controller and the gated domain.
// gated_cycles exists only when CG_CTRL_STATS_EN is defined.
interface clk_gate_ctrl_if #(
  parameter int CNT_W = 16
);
  logic activity;
  logic wake_req;
  logic force_on;
  logic quiesce_req;
  logic quiesce_ack;
  logic clk_en;
  logic clk_ready;
  logic gated;
`ifdef CG_CTRL_STATS_EN
  logic [CNT_W-1:0] gated_cycles;
`endif

  modport master (
    input  activity, wake_req, force_on, quiesce_ack,
`ifdef CG_CTRL_STATS_EN
    output gated_cycles,
`endif
    output quiesce_req, clk_en, clk_ready, gated
  );

  modport slave (
    output activity, wake_req, force_on, quiesce_ack,
`ifdef CG_CTRL_STATS_EN
    input  gated_cycles,
`endif
    input  quiesce_req, clk_en, clk_ready, gated
  );

endinterface

// File: rtl/clk_gate_ctrl.sv
// Idle-detect / wake controller driving the enable of one ICG cell.
// Optional gated-cycle statistics counter is built when CG_CTRL_STATS_EN is defined.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
  parameter int WAKE_CYCLES = DEFAULT_WAKE_CYCLES,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  clk_gate_ctrl_if.master bus
);

  if (IDLE_CYCLES < 1 || IDLE_CYCLES > 65535) begin : g_bad_idle
    $error("clk_gate_ctrl: IDLE_CYCLES must be in 1..65535");
  end
  if (WAKE_CYCLES < 1 || WAKE_CYCLES > 255) begin : g_bad_wake
    $error("clk_gate_ctrl: WAKE_CYCLES must be in 1..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("clk_gate_ctrl: CNT_W must be at least 1");
  end

  localparam int TW = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_CYCLES - 1);
  localparam logic [TW-1:0] WAKE_LAST = TW'(WAKE_CYCLES - 1);

  state_e        state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          wake;

  assign wake    = bus.activity | bus.wake_req | bus.force_on;
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (!wake) begin
          state_nxt = IDLE_WAIT;
          cnt_nxt   = '0;
        end
      end
      IDLE_WAIT: begin
        if (wake) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt == IDLE_LAST) begin
          state_nxt = QUIESCE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      QUIESCE: begin
        // A late wake beats a simultaneous drain ack: never gate a busy domain.
        if (wake)                 state_nxt = RUN;
        else if (bus.quiesce_ack) state_nxt = OFF;
      end
      OFF: begin
        if (wake) begin
          state_nxt = WAKE;
          cnt_nxt   = '0;
        end
      end
      WAKE: begin
        if (cnt == WAKE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = WAKE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so ICG en is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all sequential state avoid ordering races.
      state           <= WAKE;
      cnt             <= '0;
      bus.clk_en      <= 1'b1;
      bus.clk_ready   <= 1'b0;
      bus.quiesce_req <= 1'b0;
      bus.gated       <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      bus.clk_en      <= (state_nxt != OFF);
      bus.clk_ready   <= (state_nxt == RUN) || (state_nxt == IDLE_WAIT) ||
                         (state_nxt == QUIESCE);
      bus.quiesce_req <= (state_nxt == QUIESCE);
      bus.gated       <= (state_nxt == OFF);
    end
  end

`ifdef CG_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.gated_cycles <= '0;
    end else if (state == OFF && !(&bus.gated_cycles)) begin
      bus.gated_cycles <= bus.gated_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Idle-detect and wake controller that drives the enable input of the integrated clock gating cell for one gated domain.
- Watches domain activity and counts idle cycles with hysteresis. Runs a quiesce handshake before dropping the enable.
- On wake, re-enables the clock and signals clk_ready once the gated clock is stable.
- Sits upstream of the ICG cell: clk_en connects to ICG en. ICG test_en bypass stays in the ICG.

Parameters:
- IDLE_CYCLES, 16, consecutive idle cycles in IDLE_WAIT before quiesce is requested; legal range 1..65535.
- WAKE_CYCLES, 2, cycles clk_en is held high before clk_ready asserts; legal range 1..255.
- CNT_W, 16, width of the gated-cycle statistics counter (optional feature only).

Ports:
- clk  in  1  free-running source clock; same clock that feeds the ICG.
- rst_n  in  1  asynchronous, active-low reset.
- activity  in  1  level; domain has pending or in-flight work.
- wake_req  in  1  level; external wake request.
- force_on  in  1  level; software override; while high the clock is never gated.
- quiesce_req  out  1  request to the domain to drain before gating.
- quiesce_ack  in  1  domain drained; sampled only in QUIESCE.
- clk_en  out  1  enable to the ICG.
- clk_ready  out  1  gated clock is stable; the domain may accept work.
- gated  out  1  status; high while in OFF.
- gated_cycles  out  CNT_W  cycles spent in OFF (optional feature only).

Behaviour:
- All outputs are registered. They change only on posedge clk, so ICG en never changes combinationally.
- Reset value of every output: clk_en=1, clk_ready=0, quiesce_req=0, gated=0, gated_cycles=0.
- Reset state is WAKE with the counter at 0, so clk_ready rises WAKE_CYCLES cycles after rst_n deasserts.
- The assertion of rst_n is asynchronous. Mid-operation reset forces the reset values immediately, from any state.
- Define wake = activity | wake_req | force_on.
- RUN: clk_en=1, clk_ready=1. If !wake → IDLE_WAIT with counter=0.
- IDLE_WAIT: clk_en=1, clk_ready=1. Counter increments every cycle while !wake.
  - wake → RUN, counter cleared.
  - Counter == IDLE_CYCLES-1 with !wake → QUIESCE.
- QUIESCE: quiesce_req=1, clk_en=1, clk_ready=1.
  - wake → RUN and quiesce_req drops. wake has priority over quiesce_ack in the same cycle.
  - quiesce_ack with !wake → OFF.
- OFF: clk_en=0, clk_ready=0, quiesce_req=0, gated=1.
  - wake → WAKE with counter=0. clk_en returns to 1 on that same edge, i.e. one cycle after wake is sampled.
- WAKE: clk_en=1, clk_ready=0.
  - Counter increments every cycle. At WAKE_CYCLES-1 → RUN.
  - wake dropping during WAKE is ignored; WAKE always completes to RUN.
- Minimum gating latency: 1 (RUN→IDLE_WAIT) + IDLE_CYCLES + 1 (QUIESCE with ack already high) cycles from wake falling to clk_en=0.
- Wake latency: clk_en=1 one cycle after wake. clk_ready=1 WAKE_CYCLES cycles later.
- force_on held high keeps the controller in RUN indefinitely.
- Counter is a single shared counter, sized for max(IDLE_CYCLES, WAKE_CYCLES). It saturates and never wraps.
- Elaboration error if IDLE_CYCLES < 1 or WAKE_CYCLES < 1.

Optional Feature:
- Macro: CG_CTRL_STATS_EN.
- Defined:
  - gated_cycles port exists.
  - It increments once per cycle while state is OFF and saturates at all-ones (no wrap).
  - It clears on reset only.
- Undefined: gated_cycles port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package clk_gate_ctrl_pkg holds:
  - the state enum: RUN, IDLE_WAIT, QUIESCE, OFF, WAKE (3-bit encoding).
  - the localparam for counter width, derived via $clog2 of the max of the two parameters.
- No sub-module. FSM, counter and optional stats counter all live in one module.

Test Plan:
- Reset release with all inputs 0 → clk_en=1 throughout, clk_ready rises at cycle 2, then gating sequence starts.
- activity 1→0, quiesce_ack tied 1, IDLE_CYCLES=16 → quiesce_req high at cycle 17, clk_en=0 and gated=1 at cycle 18.
- activity pulses for 1 cycle at idle cycle 10 → counter restarts; clk_en=0 only 16 idle cycles after that pulse.
- In QUIESCE, quiesce_ack and activity rise in the same cycle → next state RUN, clk_en stays 1, quiesce_req=0, gated=0.
- In OFF, wake_req pulses 1 cycle → clk_en=1 next cycle, clk_ready=1 two cycles later even though wake_req is gone.
- With CG_CTRL_STATS_EN, stay in OFF for 100 cycles → gated_cycles=100. force_on=1 then → WAKE/RUN and the count freezes at 100.
